uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Upstream stage of the 6-bit serial transmitter. Buffers 6-bit words from a producer (test sequencer, result logger) in a small FIFO and launches them one at a time into the transmitter through its start/busy handshake, keeping `out_mem` stable for the whole frame. It decouples bursty producers from the ~2440-cycle frame time of the transmitter.

## Interface
- `DEPTH`, 16: FIFO depth in words; power of two, 2..256.
- `TMO`, 15: cycles allowed between start and busy rising. Used only with the timeout feature.
- `in_clk` input 1: clock.
- `in_rst_n` input 1: reset; one clock; reset is asynchronous and active-low.
- `in_data` input 6: word from producer.
- `in_valid` input 1: producer offers `in_data`.
- `out_ready` output 1: FIFO can accept; transfer when `in_valid & out_ready`.
- `out_level` output $clog2(DEPTH)+1: words in FIFO.
- `out_mem` output 6: word to transmitter data input.
- `out_utx_st` output 1: one-cycle start pulse to transmitter.
- `in_utx_bs` input 1: transmitter busy.
- `out_idle` output 1: FIFO empty and FSM in IDLE.
- `out_err` output 1: sticky timeout flag; tied 0 without the timeout feature.

## Operation
- FIFO: registered read/write pointers, each `$clog2(DEPTH)+1` bits, wrapping modulo 2·DEPTH. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- `out_ready` = !full and is combinational from the registered pointers. A push while full is dropped, even if a pop happens the same cycle.
- Push and pop in the same cycle, not full: level unchanged, both pointers advance.
- FSM states: IDLE, START, WAIT_BS, WAIT_DONE.
  - IDLE: if FIFO not empty, latch head into the `out_mem` register, pop, go to START.
  - START: `out_utx_st`=1 for exactly this cycle, then WAIT_BS.
  - WAIT_BS: stay until `in_utx_bs`=1, then WAIT_DONE.
  - WAIT_DONE: stay until `in_utx_bs`=0, then IDLE.
- `out_mem` changes only on the IDLE→START transition. It holds through the frame until the next launch.
- Consecutive words: minimum 2 cycles from busy falling to the next start pulse (WAIT_DONE→IDLE→START).
- Reset mid-frame: FIFO emptied, FSM to IDLE, `out_mem`=0. The transmitter is reset separately by the system.

## Timing
- Reset values:
  - `out_ready`=1
  - `out_level`=0
  - `out_mem`=0
  - `out_utx_st`=0
  - `out_idle`=1
  - `out_err`=0
- Empty FIFO push in cycle N: `out_level`=1 in N+1. Pop and `out_mem` load at the N+1 clock edge. `out_utx_st`=1 in cycle N+2.
- Transmitter raises busy 1 cycle after start. WAIT_BS therefore lasts 1 cycle nominally.
- All outputs are registered except `out_ready` and `out_idle`, which are decoded from registers.

## Configuration
- `UART_FEED_TIMEOUT_EN` defined:
  - WAIT_BS counts cycles.
  - If `in_utx_bs` is still 0 after TMO cycles, set `out_err` (sticky until reset) and go to IDLE. The word is discarded.
- Undefined: no counter; WAIT_BS waits indefinitely; `out_err` tied 0.

## Structure
- Package `uart_pkg`:
  - `UART_DATA_W`=6
  - `feed_state_t` enum (IDLE, START, WAIT_BS, WAIT_DONE)
  - default `TMO`
- Sub-module `uart_feed_fifo`: parameterised sync FIFO with level output.
- FSM and timeout counter live in the top.

## Test plan
- Reset, then push 6'h2A: `out_utx_st` pulses 2 cycles later with `out_mem`=6'h2A. Model busy for 2440 cycles. `out_idle`=1 two cycles after busy falls.
- Push 3 words back-to-back (6'h01, 6'h3F, 6'h15): three start pulses in order, each ≥2 cycles after the previous busy fall. `out_mem` is stable during each busy window.
- Push 17 words with busy held 1: first word pops, 16 buffered. `out_ready`=0 with `out_level`=16. The 18th push is dropped.
- At full with a pop in the same cycle, push 6'h07: push rejected; `out_level` goes 16→15.
- With `UART_FEED_TIMEOUT_EN`, hold busy 0 after start: `out_err`=1 exactly TMO cycles into WAIT_BS, FSM returns to IDLE, and the next word launches.
- Assert `in_rst_n`=0 mid-frame with 5 words queued: outputs take reset values asynchronously and `out_level`=0. No start pulse after release until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the 6-bit UART transmit path.
package uart_pkg;

   localparam int UART_DATA_W         = 6;
   localparam int UART_FEED_DEPTH_DEF = 16;
   localparam int UART_TMO_DEF        = 15;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BS   = 2'd2,
      ST_WAIT_DONE = 2'd3
   } feed_state_t;

endpackage

// File: rtl/uart_feed_fifo.sv
// Synchronous word FIFO with wrap-bit pointers and a registered fill level.
module uart_feed_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_FEED_DEPTH_DEF,
   parameter int W     = UART_DATA_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [W-1:0]           i_wdata,
   input  logic                   i_push,
   input  logic                   i_pop,
   output logic [W-1:0]           o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic [AW:0]  r_level;
   logic [W-1:0] r_mem [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   // Pointers carry one extra wrap bit so full and empty stay distinguishable.
   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign w_do_push = i_push && !w_full;
   assign w_do_pop  = i_pop && !w_empty;

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wptr[AW-1:0]] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rptr[AW-1:0]];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_level = r_level;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer words and launches them one at a time into the serial transmitter.
// Optional start/busy watchdog enabled by defining UART_FEED_TIMEOUT_EN.
//
// state        | meaning
// ST_IDLE      | no frame in flight; pops the head word when the FIFO is not empty
// ST_START     | start pulse on out_utx_st for this single cycle
// ST_WAIT_BS   | waiting for the transmitter to raise busy (watchdog counts here)
// ST_WAIT_DONE | frame in progress; waiting for busy to drop
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_FEED_DEPTH_DEF
`ifdef UART_FEED_TIMEOUT_EN
   ,
   parameter int TMO   = UART_TMO_DEF
`endif
) (
   input  logic                   in_clk,
   input  logic                   in_rst_n,
   input  logic [UART_DATA_W-1:0] in_data,
   input  logic                   in_valid,
   output logic                   out_ready,
   output logic [$clog2(DEPTH):0] out_level,
   output logic [UART_DATA_W-1:0] out_mem,
   output logic                   out_utx_st,
   input  logic                   in_utx_bs,
   output logic                   out_idle,
   output logic                   out_err
);

   feed_state_t            r_state;
   logic [UART_DATA_W-1:0] r_mem;
   logic                   r_st;

   logic [UART_DATA_W-1:0] w_head;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;

   assign w_pop = (r_state == ST_IDLE) && !w_empty;

   uart_feed_fifo #(
      .DEPTH (DEPTH),
      .W     (UART_DATA_W)
   ) u_fifo (
      .i_clk   (in_clk),
      .i_rst_n (in_rst_n),
      .i_wdata (in_data),
      .i_push  (in_valid),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (out_level)
   );

`ifdef UART_FEED_TIMEOUT_EN
   localparam int              CW       = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [CW-1:0]   TMO_LOAD = CW'(TMO - 1);

   logic [CW-1:0] r_tmo_cnt;
   logic          r_err;

   // The watchdog is a down-counter; hitting zero without busy abandons the word.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state   <= ST_IDLE;
         r_mem     <= '0;
         r_st      <= 1'b0;
         r_tmo_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         r_st <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_mem   <= w_head;
                  r_st    <= 1'b1;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               r_tmo_cnt <= TMO_LOAD;
               r_state   <= ST_WAIT_BS;
            end
            ST_WAIT_BS: begin
               if (in_utx_bs) begin
                  r_state <= ST_WAIT_DONE;
               end else if (r_tmo_cnt == '0) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt - 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!in_utx_bs) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_err = r_err;
`else
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state <= ST_IDLE;
         r_mem   <= '0;
         r_st    <= 1'b0;
      end else begin
         r_st <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_mem   <= w_head;
                  r_st    <= 1'b1;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               r_state <= ST_WAIT_BS;
            end
            ST_WAIT_BS: begin
               if (in_utx_bs) begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (!in_utx_bs) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_err = 1'b0;
`endif

   assign out_ready  = !w_full;
   assign out_mem    = r_mem;
   assign out_utx_st = r_st;
   assign out_idle   = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: queue-based launch model plus a simple transmitter model.
module tb_uart_tx_feeder;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int TMO   = UART_TMO_DEF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    in_data;
   logic          in_valid;
   logic          bs;
   logic          ready;
   logic [LW-1:0] level;
   logic [5:0]    mem;
   logic          st;
   logic          idle;
   logic          err;

   int n_cmp  = 0;
   int n_fail = 0;

   uart_tx_feeder #(.DEPTH(DEPTH)) dut (
      .in_clk     (clk),
      .in_rst_n   (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_ready  (ready),
      .out_level  (level),
      .out_mem    (mem),
      .out_utx_st (st),
      .in_utx_bs  (bs),
      .out_idle   (idle),
      .out_err    (err)
   );

   always #5 clk = ~clk;

   // transmitter: 0 = frame of frame_len busy cycles, 1 = busy stuck high, 2 = never busy
   int tx_mode;
   int frame_len;
   int tx_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bs     <= 1'b0;
         tx_cnt <= 0;
      end else if (tx_mode == 1) begin
         bs <= 1'b1;
      end else if (tx_mode == 2) begin
         bs <= 1'b0;
      end else if (st) begin
         bs     <= 1'b1;
         tx_cnt <= frame_len - 1;
      end else if (bs) begin
         if (tx_cnt == 0) bs <= 1'b0;
         else             tx_cnt <= tx_cnt - 1;
      end
   end

   logic [5:0] launched[$];
   always @(posedge clk) begin
      if (rst_n && st) launched.push_back(mem);
   end

   // reference: queue of accepted words and one launch in flight at a time
   logic [5:0] m_q[$];
   logic [5:0] m_mem;
   bit         m_st, m_err, m_inflight, m_seen, m_full;
   int         m_age;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_mem = 6'd0; m_st = 0; m_err = 0; m_inflight = 0; m_seen = 0; m_age = 0;
      end else begin
         m_full = (m_q.size() == DEPTH);
         m_st   = 0;
         if (m_inflight) begin
            m_age++;
            if (m_seen) begin
               if (!bs) m_inflight = 0;
            end else if (m_age >= 2) begin
               if (bs) m_seen = 1;
`ifdef UART_FEED_TIMEOUT_EN
               else if (m_age == TMO + 1) begin
                  m_err = 1;
                  m_inflight = 0;
               end
`endif
            end
         end else if (m_q.size() > 0) begin
            m_mem = m_q.pop_front();
            m_inflight = 1; m_seen = 0; m_age = 0; m_st = 1;
         end
         if (in_valid && !m_full) m_q.push_back(in_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("level", 32'(level), 32'(m_q.size()));
      check("ready", 32'(ready), 32'(m_q.size() < DEPTH));
      check("mem",   32'(mem),   32'(m_mem));
      check("start", 32'(st),    32'(m_st));
      check("idle",  32'(idle),  32'(!m_inflight && m_q.size() == 0));
      check("err",   32'(err),   32'(m_err));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic push_one(input logic [5:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic run_idle(input int budget);
      int i;
      i = 0;
      while (idle !== 1'b1 && i < budget) begin
         step();
         i++;
      end
      check("wait_idle", 32'(idle), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, 32'(ready), 32'd1);
      check({tag, "_level"}, 32'(level), 32'd0);
      check({tag, "_mem"},   32'(mem),   32'd0);
      check({tag, "_st"},    32'(st),    32'd0);
      check({tag, "_idle"},  32'(idle),  32'd1);
      check({tag, "_err"},   32'(err),   32'd0);
   endtask

   initial begin
      int cnt;
      int hits;
      rst_n = 1'b1; in_valid = 1'b0; in_data = 6'd0; tx_mode = 0; frame_len = 2440;
      #2 rst_n = 1'b0;
      #1 check_reset_vals("rst");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      step(); step();

      // single word, full-length frame
      push_one(6'h2A);
      check("t1_level", 32'(level), 32'd1);
      step();
      check("t1_start", 32'(st), 32'd1);
      check("t1_mem", 32'(mem), 32'h2A);
      run_idle(3000);

      // three back-to-back words
      frame_len = 40;
      launched.delete();
      push_one(6'h01); push_one(6'h3F); push_one(6'h15);
      run_idle(500);
      check("t2_count", 32'(launched.size()), 32'd3);
      if (launched.size() == 3) begin
         check("t2_w0", 32'(launched[0]), 32'h01);
         check("t2_w1", 32'(launched[1]), 32'h3F);
         check("t2_w2", 32'(launched[2]), 32'h15);
      end

      // fill to full with busy stuck high
      launched.delete();
      tx_mode = 1;
      for (int i = 0; i < 17; i++) push_one(6'(i + 8));
      check("t3_level", 32'(level), 32'd16);
      check("t3_ready", 32'(ready), 32'd0);
      push_one(6'h3E);
      check("t3_drop", 32'(level), 32'd16);

      // push at full on the cycle the head pops
      tx_mode = 0;
      cnt = 0;
      while (m_inflight && cnt < 20) begin step(); cnt++; end
      push_one(6'h07);
      check("t4_level", 32'(level), 32'd15);
      check("t4_ready", 32'(ready), 32'd1);
      run_idle(16 * 60);
      check("t4_count", 32'(launched.size()), 32'd17);
      hits = 0;
      foreach (launched[i]) if (launched[i] == 6'h07 || launched[i] == 6'h3E) hits++;
      check("t4_rejected", 32'(hits), 32'd0);

`ifdef UART_FEED_TIMEOUT_EN
      // transmitter never answers
      launched.delete();
      tx_mode = 2;
      push_one(6'h11);
      cnt = 0;
      while (st !== 1'b1 && cnt < 10) begin step(); cnt++; end
      check("to_start", 32'(st), 32'd1);
      cnt = 0;
      while (err !== 1'b1 && cnt < TMO + 20) begin step(); cnt++; end
      check("to_delay", 32'(cnt), 32'(TMO + 1));
      tx_mode = 0;
      push_one(6'h22);
      run_idle(200);
      check("to_count", 32'(launched.size()), 32'd2);
      if (launched.size() == 2) check("to_next", 32'(launched[1]), 32'h22);
`endif

      // random traffic
      frame_len = $urandom_range(3, 25);
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) == 0);
         in_data  = 6'($urandom_range(0, 63));
         step();
      end
      in_valid = 1'b0;
      run_idle(DEPTH * 40 + 200);

      // reset mid-frame with five words queued
      frame_len = 40;
      for (int i = 0; i < 6; i++) push_one(6'(i + 40));
      repeat (8) step();
      check("t6_level", 32'(level), 32'd5);
      #3 rst_n = 1'b0;
      #1 check_reset_vals("t6_rst");
      launched.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (20) step();
      check("t6_nostart", 32'(launched.size()), 32'd0);
      push_one(6'h2D);
      run_idle(100);
      check("t6_recover", 32'(launched.size()), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
